mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences memory-stage data accesses (load/store) against a variable-latency backing data memory.
- Stalls the fetch-through-memory pipeline while an access is outstanding.
- Inserts bubbles into the MEM/WB register during the stall.
- Presents the captured load data to the MEM/WB register in a single release cycle.
- Sits between the MEM stage and the data memory port, alongside the MEM/WB pipeline register.

Parameters:
- DATA_WIDTH, 32, width of addresses, write data and read data.
- TIMEOUT, 255, maximum BUSY cycles to wait for mem_ack before aborting (must be ≥1).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- MemReadM  in  1  MEM-stage instruction is a load.
- MemWriteM  in  1  MEM-stage instruction is a store.
- ALUResultM  in  DATA_WIDTH  byte address of the access.
- WriteDataM  in  DATA_WIDTH  store data.
- ByteEnM  in  4  store byte enables.
- mem_req  out  1  request to backing memory.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  DATA_WIDTH  registered address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_be  out  4  registered byte enables.
- mem_ack  in  1  memory completion (single-cycle pulse).
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack=1.
- StallM  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- BubbleW  out  1  force RegWriteW=0 into the MEM/WB register.
- ReadDataM  out  DATA_WIDTH  load data to the MEM/WB register.
- timeout_err  out  1  sticky abort flag.
- stall_cnt  out  32  saturating count of stalled cycles.

Behaviour:
- Clocking and reset:
  - One clock (clk), rising edge.
  - rst_n is asynchronous, active-low.
  - On reset: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; rdata_q=0; timeout_err=0; stall_cnt=0; wait_cnt=0.
- Definition: access = MemReadM | MemWriteM. Both asserted together is treated as a write.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access: latch ALUResultM, WriteDataM, ByteEnM and MemWriteM into mem_addr, mem_wdata, mem_be and mem_we. Set mem_req=1, wait_cnt=0, go to BUSY.
  - Else stay in IDLE.
- BUSY:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_be are held stable.
  - On mem_ack=1:
    - If the access is a read, rdata_q <= mem_rdata. A write leaves rdata_q unchanged.
    - Then mem_req <= 0, go to DONE.
  - On mem_ack=0:
    - If wait_cnt == TIMEOUT-1: mem_req <= 0, rdata_q <= 0, timeout_err <= 1, go to DONE.
    - Otherwise wait_cnt++.
  - If mem_ack arrives in the timeout cycle, the ack wins and timeout_err is not set.
- DONE: unconditionally go to IDLE. A following access is detected in IDLE on the next cycle.
- mem_ack is ignored in IDLE and DONE.
- Combinational outputs:
  - StallM = (state==IDLE & access) | (state==BUSY).
  - BubbleW = StallM.
  - ReadDataM = rdata_q at all times.
- Latency (ack k cycles after mem_req rises, k≥0):
  - mem_req rises one cycle after the access is seen in IDLE.
  - Stall length = k+2 cycles; the release cycle is DONE.
  - Minimum: ack in the first BUSY cycle gives 2 stall cycles, 3 cycles total.
- Non-access instructions: zero stall, no state change.
- stall_cnt: +1 on every cycle with StallM=1; saturates at 0xFFFFFFFF.
- timeout_err: stays 1 until reset. Later accesses proceed normally.
- Reset mid-operation: mem_req drops immediately (asynchronously). Any late mem_ack is ignored in IDLE.
- Width rule: wait_cnt width = $clog2(TIMEOUT+1).

Test Plan:
- Load, addr 0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after mem_req rises → StallM high 5 cycles; ReadDataM=0xDEADBEEF in DONE; BubbleW matches StallM; stall_cnt=5.
- Store, addr 0x200, data 0x12345678, ByteEnM=4'b0011, ack in first BUSY cycle → mem_we=1, mem_be=0011, mem_wdata stable while req high; 2 stall cycles; rdata_q unchanged.
- Back-to-back load, load, each acked immediately → second access detected in the cycle after DONE; 4 total stall cycles; both data values delivered in order.
- TIMEOUT=4, no ack → mem_req high exactly 4 cycles; timeout_err=1; ReadDataM=0; next access still completes with timeout_err still 1.
- Ack in the 4th BUSY cycle with TIMEOUT=4 → data captured, timeout_err stays 0.
- rst_n pulsed low mid-BUSY → mem_req=0 asynchronously, StallM=0, state IDLE; a stray ack after reset has no effect.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores against a variable-latency data memory.
//   Inputs : clk, rst_n (async, active-low), MemReadM, MemWriteM, ALUResultM, WriteDataM,
//            ByteEnM, mem_ack, mem_rdata
//   Outputs: mem_req, mem_we, mem_addr, mem_wdata, mem_be (registered memory request),
//            StallM, BubbleW (pipeline hold / MEM-WB bubble), ReadDataM (captured load data),
//            timeout_err (sticky abort flag), stall_cnt (saturating stalled-cycle count)
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [3:0]            ByteEnM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  StallM,
    output logic                  BubbleW,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  timeout_err,
    output logic [31:0]           stall_cnt
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] ONE = WW'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [WW-1:0]         r_wait;
    logic                  w_access, w_stall, w_last;

    always_comb begin
        w_access    = MemReadM | MemWriteM;
        w_last      = r_wait == LAST_WAIT;
        w_stall     = (r_state == IDLE && w_access) || r_state == BUSY;
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_access ? BUSY : IDLE;
            BUSY:    w_state_nxt = (mem_ack || w_last) ? DONE : BUSY;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign StallM    = w_stall;
    assign BubbleW   = w_stall;
    assign ReadDataM = r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            r_rdata     <= '0;
            r_wait      <= '0;
            timeout_err <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1;
            case (r_state)
                IDLE: if (w_access) begin
                    // MemWriteM alone decides direction, so read+write resolves to a write
                    mem_addr  <= ALUResultM;
                    mem_wdata <= WriteDataM;
                    mem_be    <= ByteEnM;
                    mem_we    <= MemWriteM;
                    mem_req   <= 1'b1;
                    r_wait    <= '0;
                end
                BUSY: if (mem_ack) begin
                    // an ack in the final wait cycle takes priority over the timeout
                    if (!mem_we)
                        r_rdata <= mem_rdata;
                    mem_req <= 1'b0;
                end else if (w_last) begin
                    mem_req     <= 1'b0;
                    r_rdata     <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    r_wait <= r_wait + ONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl with TIMEOUT=4.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM, mem_ack;
    logic [31:0] ALUResultM, WriteDataM, mem_rdata;
    logic [3:0]  ByteEnM;
    logic        mem_req, mem_we, StallM, BubbleW, timeout_err;
    logic [31:0] mem_addr, mem_wdata, ReadDataM, stall_cnt;
    logic [3:0]  mem_be;

    int          total = 0;
    int          bad = 0;
    int          m_stall = 0;
    logic        m_terr = 1'b0;
    logic [31:0] exp_q[$];

    mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ByteEnM(ByteEnM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .StallM(StallM),
        .BubbleW(BubbleW), .ReadDataM(ReadDataM), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // k<0 means memory never acks; rdat is what memory returns on ack
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be, input int k,
                             input logic [31:0] rdat, input logic [31:0] exp_rd,
                             input int exp_stall, input int exp_req);
        int   stalls = 0;
        int   reqs = 0;
        logic done = 1'b0;
        exp_q.push_back(exp_rd);
        m_stall += exp_stall;
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wd; ByteEnM = be;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            chk("stall", {31'b0, StallM}, {31'b0, c < exp_stall});
            chk("bubble", {31'b0, BubbleW}, {31'b0, c < exp_stall});
            if (StallM) stalls++;
            if (mem_req) begin
                reqs++;
                chk("addr", mem_addr, addr);
                chk("wdata", mem_wdata, wd);
                chk("be", {28'b0, mem_be}, {28'b0, be});
                chk("we", {31'b0, mem_we}, {31'b0, wr});
            end
            if (!StallM && c > 0) begin
                done = 1'b1;
                chk("rdata", ReadDataM, exp_q.pop_front());
                chk("req_done", {31'b0, mem_req}, 32'd0);
                chk("stall_cnt", stall_cnt, m_stall);
                chk("terr", {31'b0, timeout_err}, {31'b0, m_terr});
                MemReadM = 1'b0; MemWriteM = 1'b0; mem_ack = 1'b0;
            end else begin
                mem_ack = mem_req && k >= 0 && reqs - 1 == k;
                mem_rdata = mem_ack ? rdat : $urandom;
                @(negedge clk);
            end
        end
        chk("finished", {31'b0, done}, 32'd1);
        chk("stall_len", stalls, exp_stall);
        chk("req_len", reqs, exp_req);
    endtask

    initial begin
        rst_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; mem_ack = 1'b0;
        ALUResultM = '0; WriteDataM = '0; ByteEnM = '0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_terr", {31'b0, timeout_err}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // idle cycle with a stray ack: no stall, nothing captured
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        #1;
        chk("idle_stall", {31'b0, StallM}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("idle_req", {31'b0, mem_req}, 32'd0);
        chk("idle_rdata", ReadDataM, 32'd0);
        chk("idle_cnt", stall_cnt, 32'd0);
        // load, ack 3 cycles after req (also the final wait cycle: ack beats timeout)
        do_access(1, 0, 32'h100, 32'h0, 4'hF, 3, 32'hDEADBEEF, 32'hDEADBEEF, 5, 4);
        // store acked at once: rdata unchanged
        do_access(0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 32'hBAD0BAD0, 32'hDEADBEEF, 2, 1);
        // read+write together behaves as a write
        do_access(1, 1, 32'h204, 32'hCAFE0001, 4'b1100, 1, 32'hBAD1BAD1, 32'hDEADBEEF, 3, 2);
        // back-to-back loads
        do_access(1, 0, 32'h300, 32'h0, 4'hF, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2, 1);
        do_access(1, 0, 32'h304, 32'h0, 4'hF, 0, 32'h0BADF00D, 32'h0BADF00D, 2, 1);
        // timeout: no ack
        m_terr = 1'b1;
        do_access(1, 0, 32'h400, 32'h0, 4'hF, -1, 32'h0, 32'h0, 5, 4);
        // next access still completes, error stays sticky
        do_access(1, 0, 32'h404, 32'h0, 4'hF, 2, 32'h13572468, 32'h13572468, 4, 3);
        // reset mid-BUSY
        @(negedge clk);
        MemReadM = 1'b1; ALUResultM = 32'h500;
        @(negedge clk);
        #1;
        chk("busy_req", {31'b0, mem_req}, 32'd1);
        #1;
        rst_n = 1'b0; MemReadM = 1'b0;
        #1;
        chk("arst_req", {31'b0, mem_req}, 32'd0);
        chk("arst_stall", {31'b0, StallM}, 32'd0);
        chk("arst_cnt", stall_cnt, 32'd0);
        chk("arst_terr", {31'b0, timeout_err}, 32'd0);
        chk("arst_rdata", ReadDataM, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("stray_req", {31'b0, mem_req}, 32'd0);
        chk("stray_stall", {31'b0, StallM}, 32'd0);
        chk("stray_rdata", ReadDataM, 32'd0);
        m_stall = 0; m_terr = 1'b0;
        do_access(1, 0, 32'h600, 32'h0, 4'hF, 1, 32'h2468ACE0, 32'h2468ACE0, 3, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
